coin_change_dispenser: RTL and testbench

//  Physical change-dispense engine of the vending machine. Takes a return amount

---
 rtl/coin_change_dispenser_pkg.sv | 27 ++
 rtl/coin_change_dispenser_stock.sv | 51 +++++
 rtl/coin_change_dispenser.sv | 161 ++++++++++++++++
 tb/tb_coin_change_dispenser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/coin_change_dispenser_pkg.sv
// Shared constants for the change-dispense path: coin table, widths and the
// FSM state encoding used by both the dispenser and the coin-return logic.
package coin_change_dispenser_pkg;

    localparam int NUM_COINS  = 3;
    localparam int TOTAL_BITS = 31;

    // Default denomination values, index 0 is the lowest value.
    localparam int DEF_COIN_VAL0   = 100;
    localparam int DEF_COIN_VAL1   = 500;
    localparam int DEF_COIN_VAL2   = 1000;
    localparam int DEF_STOCK_BITS  = 8;
    localparam int DEF_INIT_STOCK  = 8;
    localparam int DEF_ACK_TIMEOUT = 15;

    typedef logic [TOTAL_BITS-1:0] amount_t;
    typedef logic [NUM_COINS-1:0]  coin_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DISPENSE,
        ST_DONE,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/coin_change_dispenser_stock.sv
// Per-denomination coin stock counters. Customer deposits increment with
// saturation; an acknowledged payout decrements. Both on the same denomination
// in the same cycle cancel out.
module coin_stock_bank
    import coin_change_dispenser_pkg::*;
#(
    parameter int STOCK_BITS = DEF_STOCK_BITS,
    parameter int INIT_STOCK = DEF_INIT_STOCK
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_COINS-1:0]            i_inc,
    input  logic [NUM_COINS-1:0]            i_dec,
    output logic [NUM_COINS*STOCK_BITS-1:0] o_stock
);

    localparam logic [STOCK_BITS-1:0] STOCK_MAX  = '1;
    localparam logic [STOCK_BITS-1:0] STOCK_INIT = STOCK_BITS'(INIT_STOCK);

    logic [STOCK_BITS-1:0] count [NUM_COINS];

    // Counter update: reset to the initial fill, then +1 / -1 per denomination.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                // NOTE: registers are updated with <= so every counter sees the
                // pre-edge values of its inputs, regardless of statement order.
                count[i] <= STOCK_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (i_inc[i] && !i_dec[i]) begin
                    if (count[i] != STOCK_MAX) begin
                        count[i] <= count[i] + STOCK_BITS'(1);
                    end
                end else if (i_dec[i] && !i_inc[i]) begin
                    // The selector never picks an empty denomination, so no underflow.
                    count[i] <= count[i] - STOCK_BITS'(1);
                end
            end
        end
    end

    // Flatten the counters, denomination i at [i*STOCK_BITS +: STOCK_BITS].
    always_comb begin
        for (int i = 0; i < NUM_COINS; i++) begin
            o_stock[i*STOCK_BITS +: STOCK_BITS] = count[i];
        end
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Change-dispense engine: greedily pays out a return amount one coin at a time
// through a valid/ack handshake with the hoppers, reports the unpaid shortfall
// and latches a fault when a hopper stops answering.
module coin_change_dispenser
    import coin_change_dispenser_pkg::*;
#(
    parameter int COIN_VAL0   = DEF_COIN_VAL0,
    parameter int COIN_VAL1   = DEF_COIN_VAL1,
    parameter int COIN_VAL2   = DEF_COIN_VAL2,
    parameter int STOCK_BITS  = DEF_STOCK_BITS,
    parameter int INIT_STOCK  = DEF_INIT_STOCK,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_return_req,
    input  logic [TOTAL_BITS-1:0]           i_return_amount,
    input  logic [NUM_COINS-1:0]            i_deposit_coin,
    input  logic                            i_coin_ack,
    output logic [NUM_COINS-1:0]            o_dispense_coin,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [TOTAL_BITS-1:0]           o_shortfall,
    output logic                            o_fault,
    output logic [NUM_COINS*STOCK_BITS-1:0] o_stock
);

    localparam int TIMER_BITS = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(ACK_TIMEOUT - 1);

    localparam amount_t COIN_VAL [NUM_COINS] = '{
        amount_t'(COIN_VAL0), amount_t'(COIN_VAL1), amount_t'(COIN_VAL2)
    };

    state_t                  state, state_next;
    amount_t                 remaining, remaining_next;
    amount_t                 shortfall, shortfall_next;
    coin_vec_t               dispense, dispense_next;
    coin_vec_t               stock_dec;
    logic [TIMER_BITS-1:0]   timer, timer_next;
    logic                    sel_found;
    coin_vec_t               sel_onehot;
    amount_t                 disp_value;
    logic [NUM_COINS*STOCK_BITS-1:0] stock_flat;

    coin_stock_bank #(
        .STOCK_BITS (STOCK_BITS),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (i_deposit_coin),
        .i_dec   (stock_dec),
        .o_stock (stock_flat)
    );

    // Greedy selector: highest denomination that fits and is in stock.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch
        // is inferred.
        sel_found  = 1'b0;
        sel_onehot = '0;
        // Ascending scan; the last hit is the highest-value candidate.
        for (int i = 0; i < NUM_COINS; i++) begin
            if (COIN_VAL[i] <= remaining &&
                stock_flat[i*STOCK_BITS +: STOCK_BITS] != '0) begin
                sel_found  = 1'b1;
                sel_onehot = coin_vec_t'(1) << i;
            end
        end
    end

    // Value of the coin currently requested from the hoppers.
    always_comb begin
        disp_value = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (dispense[i]) begin
                disp_value = COIN_VAL[i];
            end
        end
    end

    // Next-state and datapath decisions for the payout FSM.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        shortfall_next = shortfall;
        dispense_next  = dispense;
        timer_next     = timer;
        stock_dec      = '0;

        case (state)
            ST_IDLE: begin
                if (i_return_req) begin
                    remaining_next = i_return_amount;
                    shortfall_next = '0;
                    state_next     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                timer_next = '0;
                if (sel_found) begin
                    dispense_next = sel_onehot;
                    state_next    = ST_DISPENSE;
                end else begin
                    // Nothing more can be paid; whatever is left is the shortfall.
                    shortfall_next = remaining;
                    state_next     = ST_DONE;
                end
            end
            ST_DISPENSE: begin
                if (i_coin_ack) begin
                    remaining_next = remaining - disp_value;
                    stock_dec      = dispense;
                    dispense_next  = '0;
                    state_next     = ST_SELECT;
                end else if (timer == TIMER_LAST) begin
                    // Hopper never answered: drop the request and park.
                    dispense_next = '0;
                    state_next    = ST_FAULT;
                end else begin
                    timer_next = timer + TIMER_BITS'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            shortfall <= '0;
            dispense  <= '0;
            timer     <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            shortfall <= shortfall_next;
            dispense  <= dispense_next;
            timer     <= timer_next;
        end
    end

    assign o_dispense_coin = dispense;
    assign o_busy          = (state != ST_IDLE) && (state != ST_FAULT);
    assign o_done          = (state == ST_DONE);
    assign o_shortfall     = shortfall;
    assign o_fault         = (state == ST_FAULT);
    assign o_stock         = stock_flat;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: greedy payout order, shortfall,
// hopper timeout, stock saturation and reset behaviour.
module tb_coin_change_dispenser;
    import coin_change_dispenser_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            return_req;
    amount_t         return_amount;
    logic [2:0]      deposit_coin;
    logic            coin_ack;
    logic [2:0]      dispense_coin;
    logic            busy;
    logic            done;
    amount_t         shortfall;
    logic            fault;
    logic [23:0]     stock;

    int n_vec = 0;
    int n_err = 0;

    coin_change_dispenser dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_return_req    (return_req),
        .i_return_amount (return_amount),
        .i_deposit_coin  (deposit_coin),
        .i_coin_ack      (coin_ack),
        .o_dispense_coin (dispense_coin),
        .o_busy          (busy),
        .o_done          (done),
        .o_shortfall     (shortfall),
        .o_fault         (fault),
        .o_stock         (stock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a return request and act as the hopper: ack each coin ack_delay
    // cycles after it appears (dep_on_ack is deposited in the ack cycle).
    // exp_coins holds expected coin k at [k*3 +: 3].
    task automatic run_payout(input string tag, input amount_t amount, input int n_exp,
                              input logic [23:0] exp_coins, input amount_t exp_short,
                              input int ack_delay, input logic [2:0] dep_on_ack);
        int         k;
        int         cnt;
        int         first_evt;
        logic       seen_done;
        logic [2:0] prev;
        logic [2:0] exp_coin;
        k = 0; cnt = 0; first_evt = 0; seen_done = 1'b0; prev = '0;
        return_req    = 1'b1;
        return_amount = amount;
        tick();
        return_req = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_short_clr"}, {1'b0, shortfall}, 32'd0);
        for (int cyc = 2; cyc < 200 && !seen_done; cyc++) begin
            tick();
            coin_ack     = 1'b0;
            deposit_coin = '0;
            if (first_evt == 0 && (dispense_coin != '0 || done)) first_evt = cyc;
            if (done) begin
                seen_done = 1'b1;
            end else if (dispense_coin != '0) begin
                if (prev == '0) begin
                    exp_coin = (k < 8) ? exp_coins[k*3 +: 3] : 3'b000;
                    check({tag, "_coin"}, {29'd0, dispense_coin}, {29'd0, exp_coin});
                    k++;
                    cnt = 0;
                end
                cnt++;
                if (cnt == ack_delay) begin
                    coin_ack     = 1'b1;
                    deposit_coin = dep_on_ack;
                end
            end
            prev = dispense_coin;
        end
        check({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
        check({tag, "_latency"}, first_evt, 32'd2);
        check({tag, "_ncoins"}, k, n_exp);
        check({tag, "_shortfall"}, {1'b0, shortfall}, {1'b0, exp_short});
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int held;
        reset_n       = 1'b0;
        return_req    = 1'b0;
        return_amount = '0;
        deposit_coin  = '0;
        coin_ack      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_disp",  {29'd0, dispense_coin}, 32'd0);
        check("rst_short", {1'b0, shortfall}, 32'd0);
        check("rst_stock", {8'd0, stock}, 32'h080808);

        // Ack while idle must not touch stock.
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check("idle_ack_stock", {8'd0, stock}, 32'h080808);

        // 1: 1600 -> 1000, 500, 100.
        run_payout("t1", 31'd1600, 3, {15'd0, 3'b001, 3'b010, 3'b100}, 31'd0, 2, 3'b000);
        check("t1_stock", {8'd0, stock}, 32'h070707);

        // 2: empty the 1000 hopper, then 1000 must come as two 500s.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run_payout("t2a", 31'd8000, 8, {8{3'b100}}, 31'd0, 1, 3'b000);
        check("t2a_stock", {8'd0, stock}, 32'h000808);
        run_payout("t2b", 31'd1000, 2, {18'd0, 3'b010, 3'b010}, 31'd0, 2, 3'b000);
        check("t2b_stock", {8'd0, stock}, 32'h000608);

        // 3: 250 -> two 100s, shortfall 50 held; then amount 0.
        run_payout("t3a", 31'd250, 2, {18'd0, 3'b001, 3'b001}, 31'd50, 2, 3'b000);
        check("t3a_stock", {8'd0, stock}, 32'h000606);
        tick();
        check("t3a_short_hold", {1'b0, shortfall}, 32'd50);
        run_payout("t3b", 31'd0, 0, 24'd0, 31'd0, 2, 3'b000);

        // 5: deposit of a 100 coin on its own ack leaves stock unchanged.
        run_payout("t5", 31'd100, 1, {21'd0, 3'b001}, 31'd0, 2, 3'b001);
        check("t5_stock", {8'd0, stock}, 32'h000606);

        // Multi-hot deposit.
        deposit_coin = 3'b110;
        tick();
        deposit_coin = '0;
        check("multi_dep", {8'd0, stock}, 32'h010706);

        // Saturation of the 100 counter.
        deposit_coin = 3'b001;
        for (int i = 0; i < 249; i++) tick();
        deposit_coin = '0;
        check("sat_reach", {8'd0, stock}, 32'h0107ff);
        deposit_coin = 3'b001;
        tick();
        deposit_coin = '0;
        check("sat_hold", {8'd0, stock}, 32'h0107ff);

        // 4: never ack -> timeout fault.
        return_req    = 1'b1;
        return_amount = 31'd100;
        tick();
        return_req = 1'b0;
        tick();
        check("t4_coin", {29'd0, dispense_coin}, 32'd1);
        held = 1;
        for (int i = 0; i < 40 && !fault; i++) begin
            tick();
            if (dispense_coin != '0) held++;
        end
        check("t4_held", held, 32'd15);
        check("t4_fault", {31'd0, fault}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_disp", {29'd0, dispense_coin}, 32'd0);
        check("t4_stock", {8'd0, stock}, 32'h0107ff);
        return_req    = 1'b1;
        return_amount = 31'd500;
        tick();
        return_req = 1'b0;
        tick();
        check("t4_req_ign_busy", {31'd0, busy}, 32'd0);
        check("t4_req_ign_disp", {29'd0, dispense_coin}, 32'd0);
        check("t4_fault_sticky", {31'd0, fault}, 32'd1);
        deposit_coin = 3'b010;
        tick();
        deposit_coin = '0;
        check("t4_fault_dep", {8'd0, stock}, 32'h0108ff);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t4_rst_fault", {31'd0, fault}, 32'd0);
        check("t4_rst_stock", {8'd0, stock}, 32'h080808);

        // 6: reset while dispensing.
        run_payout("t6a", 31'd150, 1, {21'd0, 3'b001}, 31'd50, 2, 3'b000);
        check("t6a_stock", {8'd0, stock}, 32'h080807);
        return_req    = 1'b1;
        return_amount = 31'd500;
        tick();
        return_req = 1'b0;
        tick();
        check("t6_disp_pre", {29'd0, dispense_coin}, 32'd2);
        reset_n = 1'b0;
        tick();
        check("t6_disp",  {29'd0, dispense_coin}, 32'd0);
        check("t6_busy",  {31'd0, busy},  32'd0);
        check("t6_done",  {31'd0, done},  32'd0);
        check("t6_fault", {31'd0, fault}, 32'd0);
        check("t6_short", {1'b0, shortfall}, 32'd0);
        check("t6_stock", {8'd0, stock}, 32'h080808);
        reset_n = 1'b1;
        tick();
        tick();
        check("t6_post_disp", {29'd0, dispense_coin}, 32'd0);
        check("t6_post_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
